// File: rtl/branch_ctrl_if.sv
// Stage-2 branch bus between the pipeline and the branch controller.
// The pipeline side drives the instruction and flags; the controller returns fetch control.
interface branch_ctrl_if #(
  parameter int PC_W = 12
);
  logic            stall;
  logic [15:0]     br_ir;
  logic [PC_W-1:0] br_pc;
  logic [3:0]      szcv;
  logic            halt_req;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic            halting;

  modport master (
    output stall, br_ir, br_pc, szcv, halt_req,
    input  pc, flush, halting
  );

  modport slave (
    input  stall, br_ir, br_pc, szcv, halt_req,
    output pc, flush, halting
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: resolves stage-2 branches, drives the fetch pc and flush,
// and keeps a return-address stack for BAL/BR.
module branch_ctrl #(
  parameter int PC_W      = 12,
  parameter int RAS_DEPTH = 16,
  parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  branch_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
);
  localparam int               IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic            flush_q, flush_nx;
  logic [CNT_W-1:0] count_nx;
  logic            ovf_nx, unf_nx;
  logic            push;
  logic [PC_W-1:0] ras_mem [RAS_DEPTH];

  logic [4:0]      op5;
  logic            is_b, is_br, is_bal, is_cond, cond_taken;
  logic [15:0]     disp;
  logic [PC_W-1:0] target, ret_addr, pc_inc, top;
  logic [IDX_W-1:0] push_idx, top_idx;
  logic            s_flag, z_flag, v_flag, unused_c_flag;

  assign op5      = bus.br_ir[15:11];
  assign is_b     = (op5 == 5'b10100);
  assign is_br    = (op5 == 5'b10101);
  assign is_bal   = (op5 == 5'b10110);
  assign is_cond  = (bus.br_ir[15:10] == 6'b101110);
  assign s_flag   = bus.szcv[3];
  assign z_flag   = bus.szcv[2];
  assign v_flag   = bus.szcv[0];
  assign unused_c_flag = bus.szcv[1];

  assign disp     = {{8{bus.br_ir[7]}}, bus.br_ir[7:0]};
  assign target   = bus.br_pc + disp[PC_W-1:0];
  assign ret_addr = bus.br_pc + PC_W'(1);
  assign pc_inc   = pc_q + PC_W'(1);
  assign push_idx = IDX_W'(ras_count);
  assign top_idx  = IDX_W'(ras_count - CNT_W'(1));
  assign top      = ras_mem[top_idx];

  always_comb begin
    cond_taken = 1'b0;
    if (is_cond) begin
      case (bus.br_ir[9:8])
        2'b00:   cond_taken = z_flag;
        2'b01:   cond_taken = s_flag ^ v_flag;
        2'b10:   cond_taken = z_flag | (s_flag ^ v_flag);
        default: cond_taken = ~z_flag;
      endcase
    end
  end

  // Flush slot beats everything but stall/halt; a BR on an empty stack falls
  // through to the sequential/halt path while still raising underflow.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    flush_nx = flush_q;
    count_nx = ras_count;
    ovf_nx   = ras_overflow;
    unf_nx   = ras_underflow;
    push     = 1'b0;
    if (!bus.stall && state == RUN) begin
      if (flush_q) begin
        pc_nx    = pc_inc;
        flush_nx = 1'b0;
      end else if (is_bal) begin
        pc_nx    = target;
        flush_nx = 1'b1;
        if (ras_count == FULL) begin
          ovf_nx = 1'b1;
        end else begin
          push     = 1'b1;
          count_nx = ras_count + CNT_W'(1);
        end
      end else if (is_br && ras_count != '0) begin
        pc_nx    = top;
        flush_nx = 1'b1;
        count_nx = ras_count - CNT_W'(1);
      end else if (is_b || cond_taken) begin
        pc_nx    = target;
        flush_nx = 1'b1;
      end else begin
        if (is_br) begin
          unf_nx = 1'b1;
        end
        if (bus.halt_req) begin
          state_nx = HALTED;
        end else begin
          pc_nx    = pc_inc;
          flush_nx = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      pc_q          <= '0;
      flush_q       <= 1'b0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= state_nx;
      pc_q          <= pc_nx;
      flush_q       <= flush_nx;
      ras_count     <= count_nx;
      ras_overflow  <= ovf_nx;
      ras_underflow <= unf_nx;
    end
  end

  // Stack contents are not reset; only ras_count defines which entries are valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      ras_mem[push_idx] <= ret_addr;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.flush   = flush_q;
  assign bus.halting = (state == HALTED);
endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: hand-derived vector table plus a halt/reset
// sequence, with expected outputs queued at drive time and popped after each edge.
module tb_branch_ctrl;
  localparam int PC_W = 12;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [15:0] ir;
    logic [11:0] bpc;
    logic [3:0]  szcv;
    logic        halt;
    logic [11:0] e_pc;
    logic        e_flush;
    logic        e_halt;
    logic [1:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] ras_count;
  logic       ras_overflow;
  logic       ras_underflow;

  int errors = 0;
  int checks = 0;
  int step_no = 0;
  vec_t vecs[$];
  vec_t expq[$];

  branch_ctrl_if #(.PC_W(PC_W)) bus ();

  branch_ctrl #(.PC_W(PC_W), .RAS_DEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic stall, input logic [15:0] ir,
                              input logic [11:0] bpc, input logic [3:0] szcv, input logic halt,
                              input logic [11:0] e_pc, input logic e_flush, input logic e_halt,
                              input logic [1:0] e_cnt, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ir = ir; v.bpc = bpc; v.szcv = szcv; v.halt = halt;
    v.e_pc = e_pc; v.e_flush = e_flush; v.e_halt = e_halt;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step_no, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    bus.stall    = v.stall;
    bus.br_ir    = v.ir;
    bus.br_pc    = v.bpc;
    bus.szcv     = v.szcv;
    bus.halt_req = v.halt;
    expq.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", step_no);
    end else begin
      e = expq.pop_front();
      cmp("pc", int'(bus.pc), int'(e.e_pc));
      cmp("flush", int'(bus.flush), int'(e.e_flush));
      cmp("halting", int'(bus.halting), int'(e.e_halt));
      cmp("ras_count", int'(ras_count), int'(e.e_cnt));
      cmp("ras_overflow", int'(ras_overflow), int'(e.e_ovf));
      cmp("ras_underflow", int'(ras_underflow), int'(e.e_unf));
    end
  endtask

  task automatic runStep(input vec_t v);
    applyStimulus(v);
    @(posedge clock);
    #1;
    checkOutput();
    step_no++;
  endtask

  initial begin
    // reset, then sequential fetch
    vecs.push_back(mk(1,0,16'h0000,12'h000,4'h0,0, 12'h000,0,0,0,0,0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'(i),0,0,0,0,0));
    // B backwards, then the flush slot ignores a B
    vecs.push_back(mk(0,0,16'hA0FC,12'h010,4'h0,0, 12'h00C,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'hA040,12'h999,4'h0,0, 12'h00D,0,0,0,0,0));
    // conditionals
    vecs.push_back(mk(0,0,16'hB805,12'h020,4'b0000,0, 12'h00E,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hB805,12'h020,4'b0100,0, 12'h025,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0,    12'h026,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hB910,12'h030,4'b1000,0, 12'h040,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0,    12'h041,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hB910,12'h030,4'b1001,0, 12'h042,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hBA80,12'h005,4'b0100,0, 12'hF85,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0,    12'hF86,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hBA80,12'h005,4'b0000,0, 12'hF87,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hBA02,12'h100,4'b0001,0, 12'h102,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0,    12'h103,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hBB02,12'hFFF,4'b0000,0, 12'h001,1,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0,    12'h002,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hBB02,12'hFFF,4'b0100,0, 12'h003,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'hB805,12'h020,4'b0010,0, 12'h004,0,0,0,0,0));
    // return-address stack, depth 2
    vecs.push_back(mk(0,0,16'hB000,12'h100,4'h0,0, 12'h100,1,0,1,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h101,0,0,1,0,0));
    vecs.push_back(mk(0,0,16'hB000,12'h200,4'h0,0, 12'h200,1,0,2,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h201,0,0,2,0,0));
    vecs.push_back(mk(0,0,16'hB000,12'h300,4'h0,0, 12'h300,1,0,2,1,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h301,0,0,2,1,0));
    vecs.push_back(mk(0,0,16'hA800,12'h301,4'h0,0, 12'h201,1,0,1,1,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h202,0,0,1,1,0));
    vecs.push_back(mk(0,0,16'hA800,12'h202,4'h0,0, 12'h101,1,0,0,1,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h102,0,0,0,1,0));
    vecs.push_back(mk(0,0,16'hA800,12'h102,4'h0,0, 12'h103,0,0,0,1,1));
    vecs.push_back(mk(0,0,16'hB000,12'h400,4'h0,0, 12'h400,1,0,1,1,1));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h401,0,0,1,1,1));
    vecs.push_back(mk(0,0,16'hA800,12'h401,4'h0,0, 12'h401,1,0,0,1,1));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h402,0,0,0,1,1));
    // stall holds a taken B, and holds a pending flush
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,16'hA010,12'h050,4'h0,0, 12'h402,0,0,0,1,1));
    vecs.push_back(mk(0,0,16'hA010,12'h050,4'h0,0, 12'h060,1,0,0,1,1));
    vecs.push_back(mk(0,1,16'h0000,12'h000,4'h0,0, 12'h060,1,0,0,1,1));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h061,0,0,0,1,1));
    // reset clears sticky flags
    vecs.push_back(mk(1,0,16'h0000,12'h000,4'h0,0, 12'h000,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,12'h000,4'h0,0, 12'h001,0,0,0,0,0));

    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++)
      runStep(vecs[i]);

    // halt, ignore inputs while halted, reset under stall
    runStep(mk(0,0,16'h0000,12'h000,4'h0,1, 12'h001,0,1,0,0,0));
    runStep(mk(0,0,16'hA010,12'h000,4'h0,0, 12'h001,0,1,0,0,0));
    runStep(mk(1,1,16'h0000,12'h000,4'h0,0, 12'h000,0,0,0,0,0));
    // reset under stall mid-redirect
    runStep(mk(0,0,16'hA010,12'h010,4'h0,0, 12'h020,1,0,0,0,0));
    runStep(mk(1,1,16'hA010,12'h010,4'h0,0, 12'h000,0,0,0,0,0));
    // taken branch beats halt_req; flush slot beats halt_req
    runStep(mk(0,0,16'hA005,12'h000,4'h0,1, 12'h005,1,0,0,0,0));
    runStep(mk(0,0,16'h0000,12'h000,4'h0,1, 12'h006,0,0,0,0,0));
    runStep(mk(0,0,16'h0000,12'h000,4'h0,1, 12'h006,0,1,0,0,0));
    runStep(mk(1,1,16'h0000,12'h000,4'h0,1, 12'h000,0,0,0,0,0));

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end
endmodule
